// File: rtl/addr_bus_router.sv
// addr_bus_router: decodes one upstream request to the lowest-index matching port, one transaction in flight.
// Optional read timeout enabled by defining ADDR_BUS_ROUTER_TIMEOUT_EN.
module addr_bus_router #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int COUNT = 4,
    parameter logic [32*32-1:0] ADDR_MASK = '0,
    parameter logic [32*32-1:0] ADDR_COMP = '0,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_req_valid,
    output logic                        s_req_ready,
    input  logic [ADDR_WIDTH-1:0]       s_req_addr,
    input  logic                        s_req_wr,
    input  logic [DATA_WIDTH-1:0]       s_req_data,
    output logic                        s_rsp_valid,
    output logic [DATA_WIDTH-1:0]       s_rsp_data,
    output logic                        s_rsp_err,
    output logic [COUNT-1:0]            m_req_valid,
    input  logic [COUNT-1:0]            m_req_ready,
    output logic [ADDR_WIDTH-1:0]       m_req_addr,
    output logic                        m_req_wr,
    output logic [DATA_WIDTH-1:0]       m_req_data,
    input  logic [COUNT-1:0]            m_rsp_valid,
    input  logic [COUNT*DATA_WIDTH-1:0] m_rsp_data,
    output logic                        dec_err,
    output logic                        busy
);
    localparam int SW = COUNT > 1 ? $clog2(COUNT) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;
    state_t state, state_nx;
    logic [SW-1:0] sel, dec_sel;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic wr_q, hit, accept, rsp_hit, tmo;
    logic [31:0] a32;
    assign a32 = 32'(s_req_addr);
    assign accept = s_req_valid && s_req_ready;
    assign rsp_hit = (state == WAIT_RSP) && m_rsp_valid[sel];
    assign s_req_ready = (state == IDLE);
    assign s_rsp_valid = (state == RESP);
    assign busy = (state != IDLE);
    assign m_req_addr = addr_q;
    assign m_req_wr = wr_q;
    assign m_req_data = data_q;
    // descending scan so the lowest matching index wins
    always_comb begin
        hit = 1'b0;
        dec_sel = '0;
        for (int i = COUNT - 1; i >= 0; i--) begin
            if ((a32 & ADDR_MASK[32*i +: 32]) == ADDR_COMP[32*i +: 32]) begin
                hit = 1'b1;
                dec_sel = SW'(i);
            end
        end
    end
    always_comb begin
        m_req_valid = '0;
        m_req_valid[sel] = (state == ISSUE);
    end
`ifdef ADDR_BUS_ROUTER_TIMEOUT_EN
    localparam logic [TIMEOUT_BITS-1:0] TLAST = TIMEOUT_BITS'((1 << TIMEOUT_BITS) - 2);
    logic [TIMEOUT_BITS-1:0] tcnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else tcnt <= (state == WAIT_RSP) ? tcnt + 1'b1 : '0;
    end
    assign tmo = (state == WAIT_RSP) && (tcnt == TLAST);
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = hit ? ISSUE : (s_req_wr ? IDLE : RESP);
            ISSUE:    if (m_req_ready[sel]) state_nx = wr_q ? IDLE : WAIT_RSP;
            WAIT_RSP: if (rsp_hit || tmo) state_nx = RESP;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel <= '0;
            addr_q <= '0;
            wr_q <= 1'b0;
            data_q <= '0;
            s_rsp_data <= '0;
            s_rsp_err <= 1'b0;
            dec_err <= 1'b0;
        end else begin
            state <= state_nx;
            dec_err <= accept && !hit;
            if (accept) begin
                sel <= dec_sel;
                addr_q <= s_req_addr;
                wr_q <= s_req_wr;
                data_q <= s_req_data;
            end
            if (rsp_hit) begin
                s_rsp_data <= m_rsp_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                s_rsp_err <= 1'b0;
            end else if (tmo || (accept && !hit && !s_req_wr)) begin
                s_rsp_data <= '1;
                s_rsp_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_addr_bus_router.sv
// tb_addr_bus_router: randomized and directed transactions checked every cycle against a transaction-timeline model.
module tb_addr_bus_router;
    localparam logic [31:0] MASK_TBL [4] = '{32'hFFF00000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000};
    localparam logic [31:0] COMP_TBL [4] = '{32'h00000000, 32'h00010000, 32'h00200000, 32'h00300000};
    localparam logic [1023:0] PMASK = {896'd0, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFF00000};
    localparam logic [1023:0] PCOMP = {896'd0, 32'h00300000, 32'h00200000, 32'h00010000, 32'h00000000};
    localparam int TMO_CYC = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic s_req_valid = 1'b0, s_req_wr = 1'b0;
    logic [31:0] s_req_addr = '0, s_req_data = '0;
    logic s_req_ready, s_rsp_valid, s_rsp_err, m_req_wr, dec_err, busy;
    logic [31:0] s_rsp_data, m_req_addr, m_req_data;
    logic [3:0] m_req_valid;
    logic [3:0] m_req_ready = '0, m_rsp_valid = '0;
    logic [127:0] m_rsp_data = '0;

    addr_bus_router #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .COUNT(4),
        .ADDR_MASK(PMASK), .ADDR_COMP(PCOMP), .TIMEOUT_BITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_wr(s_req_wr), .s_req_data(s_req_data),
        .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data), .s_rsp_err(s_rsp_err),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_wr(m_req_wr), .m_req_data(m_req_data),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
        .dec_err(dec_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic chk_en = 1'b0;
    logic exp_ready, exp_busy, exp_rv, exp_dec, exp_mwr;
    logic [3:0] exp_mv;
    logic [31:0] exp_maddr, exp_mdata;
    logic [31:0] last_data = '0;
    logic last_err = 1'b0;
    logic dec_flag = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_req_ready", 64'(s_req_ready), 64'(exp_ready));
            chk("m_req_valid", 64'(m_req_valid), 64'(exp_mv));
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("s_rsp_valid", 64'(s_rsp_valid), 64'(exp_rv));
            chk("s_rsp_data", 64'(s_rsp_data), 64'(last_data));
            chk("s_rsp_err", 64'(s_rsp_err), 64'(last_err));
            chk("dec_err", 64'(dec_err), 64'(exp_dec));
            if (exp_mv != 4'b0) begin
                chk("m_req_addr", 64'(m_req_addr), 64'(exp_maddr));
                chk("m_req_wr", 64'(m_req_wr), 64'(exp_mwr));
                chk("m_req_data", 64'(m_req_data), 64'(exp_mdata));
            end
        end
    end

    function automatic int ref_port(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASK_TBL[i]) == COMP_TBL[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return {12'h000, 20'($urandom)};
            1: return {16'h0020, 16'($urandom)};
            2: return {16'h0030, 16'($urandom)};
            3: return {16'h0021, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        m_req_ready = 4'($urandom);
        m_rsp_valid = 4'($urandom);
        m_rsp_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_exp(input logic rdy, input logic [3:0] mv, input logic bz, input logic rv, input logic dc);
        exp_ready = rdy;
        exp_mv = mv;
        exp_busy = bz;
        exp_rv = rv;
        exp_dec = dc;
    endtask

    task automatic idle_cycle();
        s_req_valid = 1'b0;
        noise();
        set_exp(1'b1, 4'b0, 1'b0, 1'b0, dec_flag);
        dec_flag = 1'b0;
        step();
    endtask

    // rspdly < 0 means the selected port never answers; hang bounds how long we then stay in the wait
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input int rdly, input int rspdly, input logic [31:0] rv, input int hang);
        int p;
        logic [3:0] oh;
        p = ref_port(a);
        s_req_valid = 1'b1;
        s_req_addr = a;
        s_req_wr = w;
        s_req_data = d;
        noise();
        set_exp(1'b1, 4'b0, 1'b0, 1'b0, dec_flag);
        dec_flag = 1'b0;
        step();
        s_req_valid = 1'b0;
        s_req_addr = $urandom;
        s_req_data = $urandom;
        s_req_wr = 1'($urandom);
        if (p < 0) begin
            if (w) begin
                dec_flag = 1'b1;
                return;
            end
            last_data = '1;
            last_err = 1'b1;
            noise();
            set_exp(1'b0, 4'b0, 1'b1, 1'b1, 1'b1);
            step();
            return;
        end
        oh = 4'(1 << p);
        exp_maddr = a;
        exp_mwr = w;
        exp_mdata = d;
        for (int k = 0; k <= rdly; k++) begin
            noise();
            m_req_ready = (m_req_ready & ~oh) | ((k == rdly) ? oh : 4'b0);
            set_exp(1'b0, oh, 1'b1, 1'b0, 1'b0);
            step();
        end
        if (w) return;
        for (int j = 0; ; j++) begin
`ifdef ADDR_BUS_ROUTER_TIMEOUT_EN
            if (rspdly < 0 && j == TMO_CYC) break;
`endif
            if (rspdly < 0 && j == hang) return;
            noise();
            m_rsp_valid = m_rsp_valid & ~oh;
            if (j == 0 && rspdly < 0) m_rsp_valid = m_rsp_valid | (4'b1000 & ~oh);
            if (j == rspdly) begin
                m_rsp_valid = m_rsp_valid | oh;
                m_rsp_data[p*32 +: 32] = rv;
            end
            set_exp(1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
            step();
            if (j == rspdly) break;
        end
        last_data = (rspdly < 0) ? 32'hFFFFFFFF : rv;
        last_err = (rspdly < 0);
        noise();
        set_exp(1'b0, 4'b0, 1'b1, 1'b1, 1'b0);
        step();
    endtask

    task automatic apply_reset();
        #1 rst_n = 1'b0;
        s_req_valid = 1'b0;
        last_data = '0;
        last_err = 1'b0;
        dec_flag = 1'b0;
        set_exp(1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
        chk("rst_s_rsp_valid", 64'(s_rsp_valid), 64'd0);
        chk("rst_s_rsp_data", 64'(s_rsp_data), 64'd0);
        chk("rst_s_rsp_err", 64'(s_rsp_err), 64'd0);
        chk("rst_dec_err", 64'(dec_err), 64'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("model_port_021", 64'(ref_port(32'h00200004)), 64'd2);
        chk("model_port_022", 64'(ref_port(32'h00010004)), 64'd0);
        chk("model_port_024", 64'(ref_port(32'h00400000)), 64'hFFFFFFFFFFFFFFFF);
        #1 rst_n = 1'b0;
        #2;
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_m_req_valid", 64'(m_req_valid), 64'd0);
        chk("init_s_rsp_data", 64'(s_rsp_data), 64'd0);
        chk("init_dec_err", 64'(dec_err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        idle_cycle();
        txn(32'h00200004, 1'b0, 32'h0, 0, 0, 32'hCAFEF00D, 0);
        chk("req021_data", 64'(s_rsp_data), 64'hCAFEF00D);
        chk("req021_err", 64'(s_rsp_err), 64'd0);
        txn(32'h00010004, 1'b0, 32'h0, 1, 2, 32'h0BADBEEF, 0);
        txn(32'h00300010, 1'b1, 32'h12345678, 5, 0, 32'h0, 0);
        txn(32'h00400000, 1'b0, 32'h0, 0, 0, 32'h0, 0);
        chk("req024_data", 64'(s_rsp_data), 64'hFFFFFFFF);
        txn(32'h00400000, 1'b1, 32'h55AA55AA, 0, 0, 32'h0, 0);
        idle_cycle();
        txn(32'h00010020, 1'b0, 32'h0, 0, -1, 32'h0, 2);
        apply_reset();
        s_req_valid = 1'b0;
        m_req_ready = 4'b0;
        m_rsp_valid = 4'b0011;
        set_exp(1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_cycle();
        for (int n = 0; n < 80; n++) begin
            txn(rand_addr(), 1'($urandom), $urandom, $urandom_range(0, 4),
                $urandom_range(0, 5), $urandom, 0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        txn(32'h00000100, 1'b0, 32'h0, 0, -1, 32'h0, 40);
        apply_reset();
        idle_cycle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
